// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register file with write-through reads,
// immediate generation and the ID/EX pipeline register with flush.
module decode_cycle #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              InstrD,
    input  logic [XLEN-1:0]          PCD,
    input  logic [XLEN-1:0]          PCPlus4D,
    input  logic                     FlushE,
    input  logic                     RegWriteW,
    input  logic [$clog2(NREGS)-1:0] RdW,
    input  logic [XLEN-1:0]          ResultW,
    output logic                     RegWriteE,
    output logic [1:0]               ResultSrcE,
    output logic                     MemWriteE,
    output logic                     JumpE,
    output logic                     BranchE,
    output logic [2:0]               ALUControlE,
    output logic                     ALUSrcE,
    output logic [XLEN-1:0]          RD1E,
    output logic [XLEN-1:0]          RD2E,
    output logic [XLEN-1:0]          ImmExtE,
    output logic [$clog2(NREGS)-1:0] Rs1E,
    output logic [$clog2(NREGS)-1:0] Rs2E,
    output logic [$clog2(NREGS)-1:0] RdE,
    output logic [XLEN-1:0]          PCE,
    output logic [XLEN-1:0]          PCPlus4E
);
    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_sel_t;

    logic [6:0]    op;
    logic [2:0]    f3;
    logic          f7b5;
    logic [AW-1:0] rs1, rs2, rd;

    assign op   = InstrD[6:0];
    assign f3   = InstrD[14:12];
    assign f7b5 = InstrD[30];
    assign rs1  = InstrD[19:15];
    assign rs2  = InstrD[24:20];
    assign rd   = InstrD[11:7];

    logic       reg_write, alu_src, mem_write, branch, jump;
    logic [1:0] result_src, alu_op;
    imm_sel_t   imm_sel;

    // Unknown opcodes fall through with every control low, acting as a bubble.
    always_comb begin
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        result_src = 2'b00;
        alu_op     = 2'b00;
        imm_sel    = IMM_NONE;
        case (op)
            OP_LW: begin
                reg_write  = 1'b1;
                imm_sel    = IMM_I;
                alu_src    = 1'b1;
                result_src = 2'b01;
            end
            OP_SW: begin
                imm_sel   = IMM_S;
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            OP_R: begin
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            OP_IALU: begin
                reg_write = 1'b1;
                imm_sel   = IMM_I;
                alu_src   = 1'b1;
                alu_op    = 2'b10;
            end
            OP_BEQ: begin
                imm_sel = IMM_B;
                branch  = 1'b1;
                alu_op  = 2'b01;
            end
            OP_JAL: begin
                reg_write  = 1'b1;
                imm_sel    = IMM_J;
                result_src = 2'b10;
                jump       = 1'b1;
            end
            default: ;
        endcase
    end

    logic [2:0] alu_control;

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            2'b01: alu_control = ALU_SUB;
            2'b10: begin
                case (f3)
                    3'b000:  alu_control = (op[5] & f7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    logic [XLEN-1:0] imm_ext;

    always_comb begin
        imm_ext = '0;
        case (imm_sel)
            IMM_I: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
            IMM_S: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
            IMM_B: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                              InstrD[11:8], 1'b0};
            IMM_J: imm_ext = {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20],
                              InstrD[30:21], 1'b0};
            default: imm_ext = '0;
        endcase
    end

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (RegWriteW && (RdW != '0)) begin
            regs_q[RdW] <= ResultW;
        end
    end

    // Writeback data bypasses the array so a same-cycle read sees it.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        if (addr == '0)
            return '0;
        else if (RegWriteW && (RdW == addr))
            return ResultW;
        else
            return regs_q[addr];
    endfunction

    logic [XLEN-1:0] rd1, rd2;
    assign rd1 = read_port(rs1);
    assign rd2 = read_port(rs2);

    logic            reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
    logic [1:0]      result_src_d;
    logic [2:0]      alu_control_d;
    logic [XLEN-1:0] rd1_d, rd2_d, imm_ext_d, pc_d, pc_plus4_d;
    logic [AW-1:0]   rs1_d, rs2_d, rd_d;

    logic            reg_write_q, mem_write_q, jump_q, branch_q, alu_src_q;
    logic [1:0]      result_src_q;
    logic [2:0]      alu_control_q;
    logic [XLEN-1:0] rd1_q, rd2_q, imm_ext_q, pc_q, pc_plus4_q;
    logic [AW-1:0]   rs1_q, rs2_q, rd_q;

    // A flush loads an all-zero bubble, overriding the decoded instruction.
    always_comb begin
        reg_write_d   = 1'b0;
        mem_write_d   = 1'b0;
        jump_d        = 1'b0;
        branch_d      = 1'b0;
        alu_src_d     = 1'b0;
        result_src_d  = 2'b00;
        alu_control_d = 3'b000;
        rd1_d         = '0;
        rd2_d         = '0;
        imm_ext_d     = '0;
        pc_d          = '0;
        pc_plus4_d    = '0;
        rs1_d         = '0;
        rs2_d         = '0;
        rd_d          = '0;
        if (!FlushE) begin
            reg_write_d   = reg_write;
            mem_write_d   = mem_write;
            jump_d        = jump;
            branch_d      = branch;
            alu_src_d     = alu_src;
            result_src_d  = result_src;
            alu_control_d = alu_control;
            rd1_d         = rd1;
            rd2_d         = rd2;
            imm_ext_d     = imm_ext;
            pc_d          = PCD;
            pc_plus4_d    = PCPlus4D;
            rs1_d         = rs1;
            rs2_d         = rs2;
            rd_d          = rd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_q   <= 1'b0;
            mem_write_q   <= 1'b0;
            jump_q        <= 1'b0;
            branch_q      <= 1'b0;
            alu_src_q     <= 1'b0;
            result_src_q  <= 2'b00;
            alu_control_q <= 3'b000;
            rd1_q         <= '0;
            rd2_q         <= '0;
            imm_ext_q     <= '0;
            pc_q          <= '0;
            pc_plus4_q    <= '0;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
        end else begin
            reg_write_q   <= reg_write_d;
            mem_write_q   <= mem_write_d;
            jump_q        <= jump_d;
            branch_q      <= branch_d;
            alu_src_q     <= alu_src_d;
            result_src_q  <= result_src_d;
            alu_control_q <= alu_control_d;
            rd1_q         <= rd1_d;
            rd2_q         <= rd2_d;
            imm_ext_q     <= imm_ext_d;
            pc_q          <= pc_d;
            pc_plus4_q    <= pc_plus4_d;
            rs1_q         <= rs1_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
        end
    end

    assign RegWriteE   = reg_write_q;
    assign ResultSrcE  = result_src_q;
    assign MemWriteE   = mem_write_q;
    assign JumpE       = jump_q;
    assign BranchE     = branch_q;
    assign ALUControlE = alu_control_q;
    assign ALUSrcE     = alu_src_q;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign ImmExtE     = imm_ext_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rd_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc_plus4_q;

endmodule
